// File: rtl/move_compact_fifo.sv
// move_compact_fifo: compacts valid move words of a batch into a FIFO, one per cycle; MOVE_CAPTURE_FIRST_EN writes capture moves first
module move_compact_fifo #(
  parameter int LANES = 16,
  parameter int MW = 19,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [LANES*MW-1:0] mv_in,
  output logic                in_ready,
  input  logic                rden,
  output logic [MW-1:0]       fifoOut,
  output logic                fifoEmpty,
  output logic                fifoFull,
  output logic [CW-1:0]       usedw,
  output logic                batch_done
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t              state_q;
  logic [LANES*MW-1:0] batch_q;
  logic [LANES-1:0]    pend_q, pend_d, valid_in, pick;
  logic [LW-1:0]       sel;
  logic [MW-1:0]       mem_q [DEPTH];
  logic [MW-1:0]       out_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q, accept, wr, rd;
  assign in_ready   = state_q == IDLE;
  assign fifoEmpty  = cnt_q == '0;
  assign fifoFull   = cnt_q == CW'(DEPTH);
  assign usedw      = cnt_q;
  assign fifoOut    = out_q;
  assign batch_done = done_q;
  assign accept     = in_valid && in_ready;
  assign wr         = state_q == SCAN && !fifoFull;
  assign rd         = rden && !fifoEmpty;
  always_comb begin
    valid_in = '0;
    for (int i = 0; i < LANES; i++) valid_in[i] = ~mv_in[i*MW+MW-1];
  end
`ifdef MOVE_CAPTURE_FIRST_EN
  logic [LANES-1:0] cap;
  always_comb begin
    cap = '0;
    for (int i = 0; i < LANES; i++) cap[i] = pend_q[i] & batch_q[i*MW];
    pick = |cap ? cap : pend_q;
  end
`else
  assign pick = pend_q;
`endif
  always_comb begin
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) if (pick[i]) sel = LW'(i);
    pend_d = pend_q & ~(LANES'(1) << sel);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      batch_q <= '0;
      pend_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      done_q <= (accept && valid_in == '0) || (wr && pend_d == '0);
      if (accept) begin
        batch_q <= mv_in;
        pend_q  <= valid_in;
        state_q <= |valid_in ? SCAN : IDLE;
      end else if (wr) begin
        pend_q  <= pend_d;
        state_q <= pend_d == '0 ? IDLE : SCAN;
      end
      if (wr) begin
        mem_q[wptr_q] <= batch_q[sel*MW +: MW];
        wptr_q        <= wptr_q + 1'b1;
      end
      if (rd) begin
        out_q  <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: tb/tb_move_compact_fifo.sv
// tb_move_compact_fifo: directed checks of batch compaction, full stall, reads and reset (LANES=16, DEPTH=4)
module tb_move_compact_fifo;
  localparam int LANES = 16, MW = 19, DEPTH = 4, CW = 3;
  logic                clk = 0, reset = 1, in_valid = 0, rden = 0;
  logic [LANES*MW-1:0] mv_in;
  logic                in_ready, fifoEmpty, fifoFull, batch_done;
  logic [MW-1:0]       fifoOut;
  logic [CW-1:0]       usedw;
  int                  checks = 0, failures = 0;
  move_compact_fifo #(.LANES(LANES), .MW(MW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mv_in(mv_in), .in_ready(in_ready),
    .rden(rden), .fifoOut(fifoOut), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
    .usedw(usedw), .batch_done(batch_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_batch();
    for (int i = 0; i < LANES; i++) mv_in[i*MW +: MW] = 19'h40000;
  endtask
  task automatic set_lane(input int lane, input logic [MW-1:0] v);
    mv_in[lane*MW +: MW] = v;
  endtask
  initial begin
    clear_batch();
    step(); step();
    reset = 0;
    check("rst_ready", in_ready, 1);
    check("rst_empty", fifoEmpty, 1);
    check("rst_full", fifoFull, 0);
    check("rst_usedw", usedw, 0);
    check("rst_out", fifoOut, 0);
    check("rst_done", batch_done, 0);
    // three sparse lanes
    set_lane(2, 19'h00102); set_lane(5, 19'h00205); set_lane(9, 19'h00309);
    in_valid = 1; step(); in_valid = 0;
    check("scan_ready", in_ready, 0);
    step(); step();
    check("scan_done_early", batch_done, 0);
    step();
    check("b1_done", batch_done, 1);
    check("b1_usedw", usedw, 3);
    check("b1_ready", in_ready, 1);
    step();
    check("b1_done_pulse", batch_done, 0);
    rden = 1;
    step(); check("rd0", fifoOut, 19'h00102);
    step(); check("rd1", fifoOut, 19'h00205);
    step(); check("rd2", fifoOut, 19'h00309);
    check("rd_empty", fifoEmpty, 1);
    step();
    check("rd_empty_hold", fifoOut, 19'h00309);
    check("rd_empty_usedw", usedw, 0);
    rden = 0;
    // all-invalid batch
    clear_batch();
    in_valid = 1; step(); in_valid = 0;
    check("inv_ready", in_ready, 1);
    check("inv_done", batch_done, 1);
    check("inv_usedw", usedw, 0);
    step();
    check("inv_done_pulse", batch_done, 0);
    // six lanes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) set_lane(i, MW'(32'h10 + i));
    in_valid = 1; step(); in_valid = 0;
    step(); step(); step(); step();
    check("full_usedw", usedw, 4);
    check("full_flag", fifoFull, 1);
    step(); step();
    check("stall_usedw", usedw, 4);
    check("stall_ready", in_ready, 0);
    check("stall_done", batch_done, 0);
    rden = 1; step(); rden = 0;
    check("stall_rd_usedw", usedw, 3);
    check("stall_rd_out", fifoOut, 19'h10);
    step();
    check("stall_refill", usedw, 4);
    rden = 1; step(); rden = 0;
    check("stall_rd2_out", fifoOut, 19'h11);
    check("stall_rd2_usedw", usedw, 3);
    step();
    check("b3_done", batch_done, 1);
    check("b3_usedw", usedw, 4);
    // reads held while a batch waits on a full FIFO
    clear_batch();
    for (int i = 0; i < 3; i++) set_lane(4 + 3 * i, MW'(32'h20 + i));
    in_valid = 1; step(); in_valid = 0;
    rden = 1;
    step(); check("rw_out0", fifoOut, 19'h12); check("rw_used0", usedw, 3);
    step(); check("rw_out1", fifoOut, 19'h13); check("rw_used1", usedw, 3);
    step(); check("rw_out2", fifoOut, 19'h14); check("rw_used2", usedw, 3);
    step(); check("rw_out3", fifoOut, 19'h15); check("rw_used3", usedw, 3);
    check("rw_done", batch_done, 1);
    step(); check("rw_out4", fifoOut, 19'h20);
    step(); check("rw_out5", fifoOut, 19'h21);
    step(); check("rw_out6", fifoOut, 19'h22);
    check("rw_empty", fifoEmpty, 1);
    rden = 0;
    // capture ordering
    clear_batch();
    set_lane(1, 19'h00102); set_lane(7, 19'h00707);
    in_valid = 1; step(); in_valid = 0;
    step(); step();
    check("cap_usedw", usedw, 2);
    rden = 1;
`ifdef MOVE_CAPTURE_FIRST_EN
    step(); check("cap_first", fifoOut, 19'h00707);
    step(); check("cap_second", fifoOut, 19'h00102);
`else
    step(); check("cap_first", fifoOut, 19'h00102);
    step(); check("cap_second", fifoOut, 19'h00707);
`endif
    rden = 0;
    // reset in the second scan cycle
    clear_batch();
    for (int i = 0; i < 5; i++) set_lane(i, MW'(32'h30 + i));
    in_valid = 1; step(); in_valid = 0;
    step();
    check("mid_usedw", usedw, 1);
    reset = 1; in_valid = 1; rden = 1;
    step();
    reset = 0; in_valid = 0; rden = 0;
    check("mr_usedw", usedw, 0);
    check("mr_empty", fifoEmpty, 1);
    check("mr_ready", in_ready, 1);
    check("mr_done", batch_done, 0);
    check("mr_out", fifoOut, 0);
    step();
    check("mr_done_after", batch_done, 0);
    check("mr_usedw_after", usedw, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/move_compact_fifo.md
MOVE_COMPACT_FIFO -- requirements
Module: move_compact_fifo

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning move words offered per batch (1..32).
REQ-002 SHALL have parameter MW, default 19, meaning move word width; bit MW-1 = invalid flag, bit 0 = capture flag.
REQ-003 SHALL have parameter DEPTH, default 64, meaning FIFO entries (power of two, >=4).
REQ-004 SHALL use one clock; reset is synchronous and active-high (ports clk, reset).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset; also clears FIFO contents.
REQ-007 in_valid  input  1  batch offered on mv_in this cycle.
REQ-008 mv_in  input  LANES*MW  batch; lane i occupies bits [i*MW+MW-1 : i*MW].
REQ-009 in_ready  output  1  block can accept a batch this cycle.
REQ-010 rden  input  1  read request.
REQ-011 fifoOut  output  MW  read data, registered.
REQ-012 fifoEmpty  output  1  FIFO holds zero entries.
REQ-013 fifoFull  output  1  FIFO holds DEPTH entries.
REQ-014 usedw  output  clog2(DEPTH+1)  current entry count.
REQ-015 batch_done  output  1  one-cycle pulse when a batch is fully written.

Function
REQ-016 SHALL implement states IDLE and SCAN; in_ready = 1 only in IDLE.
REQ-017 Batch accepted on an edge with in_valid=1 and in_ready=1: mv_in latched, pending mask = lanes whose bit MW-1 is 0.
REQ-018 Accepted batch with non-zero pending mask -> SCAN next cycle; zero mask -> stay IDLE, batch_done pulses next cycle, nothing written.
REQ-019 In SCAN, each cycle with fifoFull=0: write lowest-index pending lane, clear its pending bit.
REQ-020 In SCAN with fifoFull=1: no write, no lane dropped, pending mask held (stall).
REQ-021 Write of the last pending lane -> IDLE next cycle, batch_done=1 that next cycle.
REQ-022 Write/full decision uses registered fifoFull; a same-cycle read does not unblock a write.
REQ-023 rden=1 with fifoEmpty=0: entry popped on that edge; fifoOut shows it on the following cycle and holds until next accepted read.
REQ-024 rden=1 with fifoEmpty=1: ignored; fifoOut, usedw unchanged.
REQ-025 Simultaneous accepted read and write: usedw unchanged; pointers wrap modulo DEPTH.
REQ-026 Order preserved: first written, first read.
REQ-027 in_valid in SCAN is ignored (upstream must hold its batch while in_ready=0).

Reset
REQ-028 On reset: state IDLE, pending mask 0, pointers 0, usedw 0, fifoEmpty 1, fifoFull 0, fifoOut 0, batch_done 0, in_ready 1.
REQ-029 Reset mid-SCAN discards the remaining batch and all stored entries; no batch_done pulse.
REQ-030 Reset takes priority over in_valid and rden in the same cycle.

Configuration
REQ-031 Macro MOVE_CAPTURE_FIRST_EN compiled in: SCAN writes all pending lanes with capture bit 1 (lowest index first) before any with capture bit 0.
REQ-032 Without MOVE_CAPTURE_FIRST_EN: strict lowest-index-first order, capture bit not inspected.
REQ-033 Throughput (one write per non-full SCAN cycle) identical in both builds.

Verification
REQ-034 Reset, LANES=16: batch with lanes 2,5,9 valid (values 0x00102,0x00205,0x00309) -> SCAN 3 cycles, batch_done on 4th cycle, usedw=3, reads return 0x00102,0x00205,0x00309.
REQ-035 All-invalid batch (every bit 18 = 1) -> in_ready stays 1, batch_done pulses next cycle, usedw=0.
REQ-036 DEPTH=4, 6 valid lanes, no reads -> 4 written, fifoFull=1, stall; two reads -> remaining 2 written, batch_done, usedw=4.
REQ-037 usedw=4 full, rden held each cycle while SCAN pending -> no write in full cycle; afterwards alternating read/write keeps usedw at 3/4 boundary, no loss, order intact.
REQ-038 With MOVE_CAPTURE_FIRST_EN: lanes 1 (capture 0) and 7 (capture 1) valid -> lane 7 read first; without macro -> lane 1 first.
REQ-039 Reset asserted in 2nd SCAN cycle of 5-move batch -> next cycle usedw=0, fifoEmpty=1, in_ready=1, no batch_done.
